rr_grant_fsm: RTL and testbench

//  Round-robin arbiter that shares one resource (e.g. an FSM datapath) among
//  N_REQ requesters. A small 3-state FSM issues a one-hot grant, holds it until
//  the owner signals done, drops its request, or a hold timeout expires.
//  It then inserts one dead cycle before re-arbitrating. Sits between the

---
 rtl/rr_grant_fsm.sv | 120 ++++++++++++
 tb/tb_rr_grant_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until done,
// the owner drops its request, or the hold timeout expires, then idles one dead cycle.
module rr_grant_fsm #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_vld,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HW-1:0] HOLD_SAT  = '1;
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            st, st_n;
  logic [N_REQ-1:0]  grant_n;
  logic              grant_vld_n;
  logic [IW-1:0]     grant_idx_n;
  logic              timeout_n;
  logic [HW-1:0]     hold_cnt, hold_cnt_n;
  logic [IW-1:0]     ptr, ptr_n;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic              forced;

  // Search starts just after the last owner, so the previous owner ranks lowest.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign forced = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    st_n        = st;
    grant_n     = grant;
    grant_vld_n = grant_vld;
    grant_idx_n = grant_idx;
    hold_cnt_n  = hold_cnt;
    ptr_n       = ptr;
    timeout_n   = 1'b0;

    case (st)
      S_IDLE: begin
        if (win_found) begin
          st_n             = S_GRANT;
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          grant_vld_n      = 1'b1;
          grant_idx_n      = win_idx;
          hold_cnt_n       = '0;
        end
      end
      S_GRANT: begin
        if (hold_cnt != HOLD_SAT) hold_cnt_n = hold_cnt + HW'(1);
        if (done || !req[grant_idx] || forced) begin
          st_n        = S_RELEASE;
          grant_n     = '0;
          grant_vld_n = 1'b0;
          ptr_n       = grant_idx;
          // Timeout is only reported when neither normal release cause applies.
          timeout_n   = !done && req[grant_idx];
        end
      end
      S_RELEASE: st_n = S_IDLE;
      default: begin
        st_n        = S_IDLE;
        grant_n     = '0;
        grant_vld_n = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= PTR_RST;
    end else begin
      st        <= st_n;
      grant     <= grant_n;
      grant_vld <= grant_vld_n;
      grant_idx <= grant_idx_n;
      timeout   <= timeout_n;
      hold_cnt  <= hold_cnt_n;
      ptr       <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Self-checking bench for rr_grant_fsm: directed scenarios plus random traffic
// compared every cycle against an owner/gap-based reference model.
module tb_rr_grant_fsm;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int STARVE_BOUND = N * (MH + 2);

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how long, and whether a dead cycle is pending.
  int m_owner;
  int m_held;
  int m_gap;
  int m_last;
  int m_tout;

  int wait_c [N];

  rr_grant_fsm #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
    if (rs) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_tout = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      m_tout = 0;
      if (d || !r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end else if (MH != 0 && m_held == MH) begin
        m_last = m_owner; m_owner = -1; m_gap = 1; m_tout = 1;
      end
    end else if (m_gap != 0) begin
      m_gap = 0; m_tout = 0;
    end else begin
      m_tout = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && r[c]) begin
          m_owner = c; m_held = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("grant", grant, eg);
    check("grant_vld", grant_vld, (m_owner >= 0) ? 1 : 0);
    if (m_owner >= 0) check("grant_idx", grant_idx, m_owner);
    check("timeout", timeout, m_tout);
    check("onehot0", $onehot0(grant), 1);
    check("vld_or", grant_vld, |grant);
  endtask

  task automatic step(input logic [N-1:0] r, input logic d, input logic rs);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    compare();
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
  endtask

  logic [N-1:0] exp_order [5];
  logic [N-1:0] r;
  int n;
  int cnt;

  initial begin
    req = '0; done = 1'b0; rst = 1'b1;

    // Reset state and single-requester latency / re-grant gap.
    do_reset();
    check("rst_idx", grant_idx, 0);
    check("rst_grant", grant, 0);
    check("rst_timeout", timeout, 0);
    step(4'b0001, 1'b0, 1'b0);
    check("t1_grant_c1", grant, 4'b0001);
    check("t1_idx_c1", grant_idx, 0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check("t1_grant_c4", grant, 4'b0000);
    step(4'b0001, 1'b0, 1'b0);
    check("t1_grant_c5", grant, 4'b0000);
    step(4'b0001, 1'b0, 1'b0);
    check("t1_grant_c6", grant, 4'b0001);

    // Full rotation with wrap-around.
    do_reset();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!grant_vld && n < 10) begin
        step(4'b1111, 1'b0, 1'b0);
        n++;
      end
      check("rr_order", grant, exp_order[k]);
      check("rr_gap", n, (k == 0) ? 1 : 2);
      step(4'b1111, 1'b1, 1'b0);
    end

    // Timeout: grant visible exactly MH cycles, then a one-cycle timeout pulse.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    cnt = 0;
    while (grant_vld && cnt < 20) begin
      cnt++;
      step(4'b0100, 1'b0, 1'b0);
    end
    check("to_hold_len", cnt, MH);
    check("to_pulse", timeout, 1);
    step(4'b0100, 1'b0, 1'b0);
    check("to_pulse_end", timeout, 0);

    // done on the last allowed cycle wins over the timeout.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    for (int k = 0; k < MH - 1; k++) step(4'b0100, 1'b0, 1'b0);
    check("to_done_still_granted", grant, 4'b0100);
    step(4'b0100, 1'b1, 1'b0);
    check("to_done_grant", grant, 0);
    check("to_done_no_pulse", timeout, 0);

    // Owner drops its request; next owner is requester 3.
    do_reset();
    step(4'b0010, 1'b0, 1'b0);
    check("drop_owner1", grant, 4'b0010);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    check("drop_release", grant, 0);
    step(4'b1000, 1'b0, 1'b0);
    check("drop_idle", grant, 0);
    step(4'b1000, 1'b0, 1'b0);
    check("drop_next", grant, 4'b1000);

    // Reset mid-grant clears the pointer: requester 0 wins, with no dead cycle.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    check("rst_mid_owner", grant, 4'b0100);
    step(4'b0100, 1'b0, 1'b1);
    check("rst_mid_drop", grant, 0);
    step(4'b0101, 1'b0, 1'b0);
    check("rst_mid_regrant", grant, 4'b0001);
    check("rst_mid_idx", grant_idx, 0);

    // Random traffic against the model, with fairness tracking.
    do_reset();
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      logic d;
      logic rs;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      d  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 999) == 0);
      step(r, d, rs);
      for (int i = 0; i < N; i++) begin
        if (rs || !r[i] || grant[i]) wait_c[i] = 0;
        else wait_c[i]++;
        check("starve", (wait_c[i] <= STARVE_BOUND) ? 1 : 0, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
